// File: rtl/keccak_padder.sv
// Purpose: packs 64-bit message words into RATE_WORDS-word blocks and applies multi-rate padding.
// Latency: the block is presented on the edge after its completing word; one word per cycle while filling.
// Backpressure: buffer_full is high while a block waits for f_ack, and after the final block until reset.
// Build option: define KECCAK_PADDER_SHA3_EN for the SHA-3 pad byte 0x06; otherwise Keccak pad10*1 (0x01).
module keccak_padder #(
  parameter int RATE_WORDS = 9
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [63:0]             in,
  input  logic                    in_ready,
  input  logic                    is_last,
  input  logic [2:0]              byte_num,
  input  logic                    f_ack,
  output logic                    buffer_full,
  output logic [64*RATE_WORDS-1:0] out,
  output logic                    out_ready
);

  localparam int IDX_W = (RATE_WORDS > 1) ? $clog2(RATE_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATE_WORDS - 1);

`ifdef KECCAK_PADDER_SHA3_EN
  localparam logic [7:0] PAD_BYTE = 8'h06;
`else
  localparam logic [7:0] PAD_BYTE = 8'h01;
`endif

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    FULL   = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic             last_blk_q;
  logic [63:0]      blk_q [RATE_WORDS];
  logic             accept;
  logic             release_blk;
  logic [63:0]      pad_word;
  logic [63:0]      last_word;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACCEPT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; outputs depend only on the state register
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    release_blk = 1'b0;
    buffer_full = (state_q != ACCEPT);
    out_ready   = (state_q == FULL);
    case (state_q)
      ACCEPT: begin
        if (in_ready) begin
          accept = 1'b1;
          if (is_last || (idx_q == LAST_IDX)) begin
            state_d = FULL;
          end
        end
      end
      FULL: begin
        if (f_ack) begin
          release_blk = 1'b1;
          state_d     = last_blk_q ? DONE : ACCEPT;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = ACCEPT;
      end
    endcase
  end

  // Final-word padding: keep bytes below byte_num, insert the pad byte, zero the rest
  always_comb begin
    pad_word = '0;
    for (int k = 0; k < 8; k++) begin
      if (3'(k) < byte_num) begin
        pad_word[63-8*k -: 8] = in[63-8*k -: 8];
      end else if (3'(k) == byte_num) begin
        pad_word[63-8*k -: 8] = PAD_BYTE;
      end
    end
    last_word = pad_word;
    if (idx_q == LAST_IDX) begin
      last_word[7:0] = pad_word[7:0] | 8'h80;
    end
  end

  // Block storage, word counter and final-block flag
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q      <= '0;
      last_blk_q <= 1'b0;
      for (int i = 0; i < RATE_WORDS; i++) begin
        blk_q[i] <= '0;
      end
    end else if (release_blk) begin
      idx_q <= '0;
      for (int i = 0; i < RATE_WORDS; i++) begin
        blk_q[i] <= '0;
      end
    end else if (accept) begin
      if (is_last) begin
        last_blk_q <= 1'b1;
        for (int i = 0; i < RATE_WORDS; i++) begin
          if (IDX_W'(i) == idx_q) begin
            blk_q[i] <= last_word;
          end else if (IDX_W'(i) > idx_q) begin
            // trailing slots are zero-filled; the closing 0x80 sits in the last byte of the block
            blk_q[i] <= (i == RATE_WORDS - 1) ? 64'h80 : 64'h0;
          end
        end
      end else begin
        last_blk_q <= 1'b0;
        idx_q      <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        for (int i = 0; i < RATE_WORDS; i++) begin
          if (IDX_W'(i) == idx_q) begin
            blk_q[i] <= in;
          end
        end
      end
    end
  end

  // Word 0 occupies the most significant bits of the flattened block
  always_comb begin
    out = '0;
    for (int i = 0; i < RATE_WORDS; i++) begin
      out[64*(RATE_WORDS-i)-1 -: 64] = blk_q[i];
    end
  end

endmodule

// File: tb/tb_keccak_padder.sv
// Directed bench for keccak_padder with RATE_WORDS=9.
// Each check is an immediate assertion against hand-computed block contents.
// Flag checks cover reset, block completion, back-pressure, spurious f_ack and the DONE state.
module tb_keccak_padder;

  localparam int RW = 9;

`ifdef KECCAK_PADDER_SHA3_EN
  localparam logic [7:0] P = 8'h06;
`else
  localparam logic [7:0] P = 8'h01;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [63:0]     din;
  logic            in_ready;
  logic            is_last;
  logic [2:0]      byte_num;
  logic            f_ack;
  logic            buffer_full;
  logic [64*RW-1:0] dout;
  logic            out_ready;

  int tests = 0;
  int fails = 0;
  logic [63:0] exp_blk [RW];
  logic [63:0] hold_w;

  keccak_padder #(.RATE_WORDS(RW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in         (din),
    .in_ready   (in_ready),
    .is_last    (is_last),
    .byte_num   (byte_num),
    .f_ack      (f_ack),
    .buffer_full(buffer_full),
    .out        (dout),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] word_at(int i);
    return dout[64*(RW-i)-1 -: 64];
  endfunction

  function automatic logic [63:0] msg(int base, int i);
    return {32'(base), 32'(i)};
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_blk(string tag);
    for (int i = 0; i < RW; i++) begin
      chk($sformatf("%s_w%0d", tag, i), word_at(i), exp_blk[i]);
    end
  endtask

  task automatic clr_exp();
    for (int i = 0; i < RW; i++) exp_blk[i] = 64'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [63:0] w, logic last, logic [2:0] n);
    din      = w;
    is_last  = last;
    byte_num = n;
    in_ready = 1'b1;
    tick();
    in_ready = 1'b0;
    is_last  = 1'b0;
    byte_num = 3'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic ack();
    f_ack = 1'b1;
    tick();
    f_ack = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    din      = 64'h0;
    in_ready = 1'b0;
    is_last  = 1'b0;
    byte_num = 3'd0;
    f_ack    = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // reset state
    chk("rst_buffer_full", 64'(buffer_full), 64'd0);
    chk("rst_out_ready", 64'(out_ready), 64'd0);
    clr_exp();
    chk_blk("rst_out");

    // test 1: short message "abc     "
    send(64'h6162632020202020, 1'b1, 3'd3);
    chk("t1_out_ready", 64'(out_ready), 64'd1);
    chk("t1_buffer_full", 64'(buffer_full), 64'd1);
    clr_exp();
    exp_blk[0] = {24'h616263, P, 32'h0};
    exp_blk[8] = 64'h80;
    chk_blk("t1");
    ack();
    chk("t1_ack_out_ready", 64'(out_ready), 64'd0);
    chk("t1_ack_buffer_full", 64'(buffer_full), 64'd1);

    // test 6b: after the final block, inputs are ignored until reset
    din      = 64'hFEEDFACECAFEBABE;
    in_ready = 1'b1;
    is_last  = 1'b1;
    byte_num = 3'd2;
    tick();
    tick();
    tick();
    in_ready = 1'b0;
    is_last  = 1'b0;
    byte_num = 3'd0;
    chk("t6_done_buffer_full", 64'(buffer_full), 64'd1);
    chk("t6_done_out_ready", 64'(out_ready), 64'd0);
    chk("t6_done_w0", word_at(0), 64'h0);

    // test 5: reset mid-message, reset beats in_ready in the same cycle
    do_reset();
    for (int i = 0; i < 4; i++) send(msg(32'h5A5A0000, i), 1'b0, 3'd0);
    reset    = 1'b1;
    din      = 64'h1122334455667788;
    in_ready = 1'b1;
    is_last  = 1'b1;
    byte_num = 3'd5;
    tick();
    reset    = 1'b0;
    in_ready = 1'b0;
    is_last  = 1'b0;
    byte_num = 3'd0;
    chk("t5_rst_buffer_full", 64'(buffer_full), 64'd0);
    chk("t5_rst_out_ready", 64'(out_ready), 64'd0);
    send(64'h6162632020202020, 1'b1, 3'd3);
    chk("t5_out_ready", 64'(out_ready), 64'd1);
    clr_exp();
    exp_blk[0] = {24'h616263, P, 32'h0};
    exp_blk[8] = 64'h80;
    chk_blk("t5");
    ack();

    // test 2: block-aligned message, padding in a fresh block
    do_reset();
    for (int i = 0; i < RW; i++) begin
      chk($sformatf("t2_bf_before_w%0d", i), 64'(buffer_full), 64'd0);
      send(msg(32'hC0DE0000, i), 1'b0, 3'd0);
    end
    chk("t2_out_ready", 64'(out_ready), 64'd1);
    chk("t2_buffer_full", 64'(buffer_full), 64'd1);
    for (int i = 0; i < RW; i++) exp_blk[i] = msg(32'hC0DE0000, i);
    chk_blk("t2_b1");
    tick();
    tick();
    chk("t2_hold_buffer_full", 64'(buffer_full), 64'd1);
    chk("t2_hold_out_ready", 64'(out_ready), 64'd1);
    ack();
    chk("t2_ack_out_ready", 64'(out_ready), 64'd0);
    chk("t2_ack_buffer_full", 64'(buffer_full), 64'd0);
    send(64'hFFFFFFFFFFFFFFFF, 1'b1, 3'd0);
    chk("t2_b2_out_ready", 64'(out_ready), 64'd1);
    clr_exp();
    exp_blk[0] = {P, 56'h0};
    exp_blk[8] = 64'h80;
    chk_blk("t2_b2");
    ack();
    chk("t2_final_buffer_full", 64'(buffer_full), 64'd1);
    chk("t2_final_out_ready", 64'(out_ready), 64'd0);

    // test 3: pad byte and closing bit share the last byte of the block
    do_reset();
    for (int i = 0; i < RW - 1; i++) send(msg(32'h33330000, i), 1'b0, 3'd0);
    send(64'hA0A1A2A3A4A5A6A7, 1'b1, 3'd7);
    for (int i = 0; i < RW - 1; i++) exp_blk[i] = msg(32'h33330000, i);
    exp_blk[8] = {56'hA0A1A2A3A4A5A6, P | 8'h80};
    chk_blk("t3");
    ack();

    // test 4: word held during FULL lands in slot 0 of the next block
    do_reset();
    for (int i = 0; i < RW; i++) send(msg(32'h44440000, i), 1'b0, 3'd0);
    hold_w   = 64'hBEEF0000BEEF0001;
    din      = hold_w;
    in_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("t4_hold%0d_buffer_full", c), 64'(buffer_full), 64'd1);
      chk($sformatf("t4_hold%0d_w0", c), word_at(0), msg(32'h44440000, 0));
    end
    f_ack = 1'b1;
    tick();
    f_ack = 1'b0;
    chk("t4_ack_out_ready", 64'(out_ready), 64'd0);
    chk("t4_ack_buffer_full", 64'(buffer_full), 64'd0);
    chk("t4_ack_w0", word_at(0), 64'h0);
    tick();
    in_ready = 1'b0;
    chk("t4_taken_w0", word_at(0), hold_w);
    for (int i = 1; i < RW - 1; i++) send(msg(32'h44450000, i), 1'b0, 3'd0);
    send(64'h0123456789ABCDEF, 1'b1, 3'd0);
    chk("t4_out_ready", 64'(out_ready), 64'd1);
    exp_blk[0] = hold_w;
    for (int i = 1; i < RW - 1; i++) exp_blk[i] = msg(32'h44450000, i);
    exp_blk[8] = {P, 48'h0, 8'h80};
    chk_blk("t4");
    ack();

    // test 6a: f_ack while filling is ignored
    do_reset();
    send(msg(32'h66660000, 0), 1'b0, 3'd0);
    send(msg(32'h66660000, 1), 1'b0, 3'd0);
    ack();
    chk("t6_spur_out_ready", 64'(out_ready), 64'd0);
    chk("t6_spur_buffer_full", 64'(buffer_full), 64'd0);
    send(64'h7777777777777777, 1'b1, 3'd0);
    chk("t6_out_ready", 64'(out_ready), 64'd1);
    clr_exp();
    exp_blk[0] = msg(32'h66660000, 0);
    exp_blk[1] = msg(32'h66660000, 1);
    exp_blk[2] = {P, 56'h0};
    exp_blk[8] = 64'h80;
    chk_blk("t6");
    ack();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
